mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported unified memory between the CPU instruction-fetch path and the load/store data path.
- Accepts one request per requester and runs one memory transaction at a time.
- Returns read data and a one-cycle done pulse to the requester that owned the transaction.
- Data accesses have priority, with a starvation limit that guarantees forward progress of fetch. A watchdog aborts memory transactions that never complete.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced. Must be ≥1.
- TIMEOUT, 255: cycles in ACCESS without mem_ack before abort. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word; valid with if_done
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  32  data byte address, passed through unchanged
- dm_wdata  in  32  write data
- dm_be  in  4  byte enables
- dm_done  out  1  one-cycle completion pulse
- dm_rdata  out  32  read data; valid with dm_done; 0 for writes
- mem_req  out  1  memory command valid
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ack  in  1  memory completion, one cycle, may come in the first mem_req cycle
- mem_rdata  in  32  read data, valid with mem_ack
- err  out  1  one-cycle pulse alongside the done pulse of an aborted transaction
- bus_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- All outputs are registered.
  - Reset value of every output is 0.
  - State resets to IDLE; starvation and timeout counters reset to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, choose an owner and go to ACCESS next cycle.
  - mem_* outputs are latched from the owner's inputs: fetch uses mem_we=0, mem_be=4'hF, mem_addr={if_addr[31:2],2'b00}.
- ACCESS:
  - mem_req=1 and all command fields are held stable.
  - On mem_ack: latch mem_rdata into the owner's rdata (0 for writes), drop mem_req, go to RESP.
  - The timeout counter counts ACCESS cycles. When it reaches TIMEOUT with no ack: drop mem_req, rdata=0, assert err with the done pulse, set bus_err, go to RESP.
- RESP:
  - Owner's done=1 for exactly this cycle, then return to IDLE.
  - A request still high in this cycle is not re-arbitrated until IDLE.
- Minimum transaction length: IDLE→ACCESS→RESP, 3 cycles, with done 2 cycles after the IDLE cycle when ack is immediate.
- Arbitration (evaluated only in IDLE):
  - dm only → dm. if only → if.
  - Both → dm, unless starve_cnt == STARVE_MAX, in which case if.
  - starve_cnt increments on a dm grant while if_req=1. It clears on an if grant or whenever if_req=0 in IDLE, and saturates at STARVE_MAX.
- A requester dropping req mid-transaction has no effect: the transaction completes and done is still pulsed.
- mem_ack outside ACCESS is ignored; no state change.
- rst mid-transaction:
  - The next cycle is IDLE with all outputs 0.
  - No done pulse is issued; a later stale mem_ack is ignored.
- Address and data are not checked for alignment; dm_addr is passed through verbatim.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ACCESS, RESP}
  - owner_t enum {OWN_IF, OWN_DM}
  - a WORD_W=32 constant
- Sub-module mem_arb_timeout: loadable up-counter with clear, enable, and an expired flag at TIMEOUT. It is instantiated once.

Test Plan:
- Lone fetch: if_req, if_addr=0x00000006, ack 2 cycles after mem_req with mem_rdata=0x02268193 → mem_addr=0x00000004, mem_we=0, mem_be=4'hF, if_done 1 cycle with if_rdata=0x02268193, dm_done=0.
- Simultaneous: if_req with if_addr=0x8, plus dm write of 0xDEADBEEF to 0x100 with be=4'h3, immediate acks → first mem_req carries we=1, addr 0x100, wdata 0xDEADBEEF, be 4'h3. dm_done with dm_rdata=0, then fetch of 0x8 and if_done.
- Starvation: STARVE_MAX=2, dm_req and if_req held high, immediate acks → grant order dm, dm, if, dm, dm, if; done pulses spaced 3 cycles apart.
- Timeout: TIMEOUT=8, dm read with no ack → mem_req high exactly 8 cycles, then dm_done+err pulse with dm_rdata=0, bus_err=1 sticky. A following fetch with ack completes normally and bus_err stays 1.
- Reset mid-access: rst for 1 cycle during ACCESS, mem_ack pulsed 2 cycles later → mem_req=0 the cycle after rst, no done or err pulse, bus_err=0, and the arbiter accepts a new if_req normally.
- Request withdrawn: dm_req dropped 1 cycle into ACCESS, ack 3 cycles later with mem_rdata=0x00000022 → dm_done still pulses with dm_rdata=0x00000022.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Watchdog counter: counts cycles of a memory access and flags expiry at TIMEOUT.
// Latency: expired rises combinationally once the count equals TIMEOUT.
// Backpressure: none; the counter stops at TIMEOUT until cleared or reloaded.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT));

  // Clear beats load beats increment; the count holds once it reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one transaction at a time.
// Latency: done pulses 2 cycles after the arbitration cycle when mem_ack arrives in the first access cycle.
// Backpressure: requesters hold req until done; memory stalls with mem_ack, bounded by a TIMEOUT-cycle watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_done,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_done,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              err,
  output logic              bus_err
);

  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t          state;
  owner_t          owner;
  logic [SC_W-1:0] starve_cnt;
  logic            starved;
  logic            grant_dm;
  logic            grant_if;
  logic            tmo_load;
  logic            tmo_clr;
  logic            tmo_en;
  logic            tmo_expired;

  // Data wins ties unless fetch has already been passed over STARVE_MAX times in a row.
  assign starved  = (starve_cnt == SC_W'(STARVE_MAX));
  assign grant_dm = dm_req && !(if_req && starved);
  assign grant_if = if_req && !grant_dm;

  // Watchdog is loaded with 1 at grant so its value is the index of the current access cycle.
  assign tmo_load = (state == IDLE) && (if_req || dm_req);
  assign tmo_clr  = (state == ACCESS) && (mem_ack || tmo_expired);
  assign tmo_en   = (state == ACCESS);

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TMO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .load     (tmo_load),
    .load_val (TMO_W'(1)),
    .en       (tmo_en),
    .expired  (tmo_expired)
  );

  // Transaction FSM: arbitrate in IDLE, drive the memory command in ACCESS, pulse done in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_done    <= 1'b0;
      if_rdata   <= '0;
      dm_done    <= 1'b0;
      dm_rdata   <= '0;
      err        <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!if_req) begin
            starve_cnt <= '0;
          end
          if (grant_dm) begin
            owner     <= OWN_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            state     <= ACCESS;
            if (if_req && !starved) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_if) begin
            owner      <= OWN_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr & ~32'h3;
            mem_wdata  <= '0;
            mem_be     <= 4'hF;
            state      <= ACCESS;
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (owner == OWN_DM) begin
              dm_done  <= 1'b1;
              dm_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (tmo_expired) begin
            mem_req <= 1'b0;
            state   <= RESP;
            err     <= 1'b1;
            bus_err <= 1'b1;
            if (owner == OWN_DM) begin
              dm_done  <= 1'b1;
              dm_rdata <= '0;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= '0;
            end
          end
        end
        RESP: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          err     <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic against a transaction-level model.
// Latency: not applicable.
// Backpressure: the bench plays the memory and both requesters.
module tb_mem_arbiter;

  localparam int SM  = 2;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_done, dm_done, mem_req, mem_we, err, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference state for the randomized phase.
  bit          act, own_dm, ifp, dmp, dmwe, idle, in_acc, in_resp, cmd_we, exp_if;
  int          t_start, ack_at, starve;
  logic [31:0] ifa, dma, dmw, cmd_addr, cmd_wdata, exp_rd;
  logic [3:0]  dmb, cmd_be;
  logic [31:0] mem_m [bit [31:0]];

  mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_m.exists(a >> 2)) return mem_m[a >> 2];
    return init_word(a);
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    mem_m[a >> 2] = w;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_be = 0; mem_ack = 0; mem_rdata = 0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    // Reset state: every output low.
    check1("rst mem_req", mem_req, 1'b0);
    check1("rst mem_we", mem_we, 1'b0);
    check32("rst mem_addr", mem_addr, 32'h0);
    check32("rst mem_wdata", mem_wdata, 32'h0);
    check32("rst mem_be", {28'h0, mem_be}, 32'h0);
    check1("rst if_done", if_done, 1'b0);
    check1("rst dm_done", dm_done, 1'b0);
    check32("rst if_rdata", if_rdata, 32'h0);
    check32("rst dm_rdata", dm_rdata, 32'h0);
    check1("rst err", err, 1'b0);
    check1("rst bus_err", bus_err, 1'b0);

    // Lone fetch, ack two cycles after mem_req rises.
    if_req = 1; if_addr = 32'h6;
    tick();
    check1("t1 mem_req", mem_req, 1'b1);
    check32("t1 mem_addr", mem_addr, 32'h4);
    check1("t1 mem_we", mem_we, 1'b0);
    check32("t1 mem_be", {28'h0, mem_be}, 32'hF);
    tick();
    check1("t1 hold mem_req", mem_req, 1'b1);
    check1("t1 early if_done", if_done, 1'b0);
    tick();
    check1("t1 mem_req at ack", mem_req, 1'b1);
    mem_ack = 1; mem_rdata = 32'h0226_8193;
    tick();
    mem_ack = 0; mem_rdata = 0; if_req = 0;
    check1("t1 if_done", if_done, 1'b1);
    check32("t1 if_rdata", if_rdata, 32'h0226_8193);
    check1("t1 dm_done", dm_done, 1'b0);
    check1("t1 mem_req drop", mem_req, 1'b0);
    tick();
    check1("t1 if_done one cycle", if_done, 1'b0);

    // Simultaneous requests: data write goes first, then the fetch.
    if_req = 1; if_addr = 32'h8;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    tick();
    check1("t2 mem_req", mem_req, 1'b1);
    check1("t2 mem_we", mem_we, 1'b1);
    check32("t2 mem_addr", mem_addr, 32'h100);
    check32("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check32("t2 mem_be", {28'h0, mem_be}, 32'h3);
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 0; dm_req = 0;
    check1("t2 dm_done", dm_done, 1'b1);
    check32("t2 dm_rdata", dm_rdata, 32'h0);
    check1("t2 if_done early", if_done, 1'b0);
    tick();
    check1("t2 idle mem_req", mem_req, 1'b0);
    tick();
    check1("t2 fetch mem_req", mem_req, 1'b1);
    check32("t2 fetch addr", mem_addr, 32'h8);
    check1("t2 fetch we", mem_we, 1'b0);
    mem_ack = 1; mem_rdata = 32'h0000_1337;
    tick();
    mem_ack = 0; if_req = 0;
    check1("t2 if_done", if_done, 1'b1);
    check32("t2 if_rdata", if_rdata, 32'h0000_1337);
    tick();

    // Starvation limit: both held, ack held high, grants dm,dm,if repeating.
    dm_req = 1; dm_we = 0; dm_addr = 32'h200; if_req = 1; if_addr = 32'h20;
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      exp_if = (i % 3 == 2);
      tick();
      check1("t3 mem_req", mem_req, 1'b1);
      check32("t3 grant addr", mem_addr, exp_if ? 32'h20 : 32'h200);
      tick();
      check1("t3 if_done", if_done, exp_if);
      check1("t3 dm_done", dm_done, !exp_if);
      check32("t3 rdata", exp_if ? if_rdata : dm_rdata, 32'h1234_5678);
      if (i == 5) begin
        if_req = 0; dm_req = 0; mem_ack = 0;
      end
      tick();
      check1("t3 gap mem_req", mem_req, 1'b0);
      check1("t3 gap done", if_done | dm_done, 1'b0);
    end

    // Watchdog: data read never acked.
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF;
    check1("t4 bus_err before", bus_err, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      check1("t4 mem_req held", mem_req, 1'b1);
      check1("t4 no early done", dm_done, 1'b0);
    end
    tick();
    dm_req = 0;
    check1("t4 mem_req drop", mem_req, 1'b0);
    check1("t4 dm_done", dm_done, 1'b1);
    check1("t4 err", err, 1'b1);
    check32("t4 dm_rdata", dm_rdata, 32'h0);
    check1("t4 bus_err", bus_err, 1'b1);
    tick();
    check1("t4 err one cycle", err, 1'b0);
    check1("t4 bus_err sticky", bus_err, 1'b1);
    if_req = 1; if_addr = 32'h40;
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 0; if_req = 0;
    check1("t4 fetch if_done", if_done, 1'b1);
    check32("t4 fetch rdata", if_rdata, 32'hCAFE_0001);
    check1("t4 fetch err", err, 1'b0);
    check1("t4 bus_err still", bus_err, 1'b1);
    tick();

    // Reset during ACCESS; stale ack afterwards must be ignored.
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    tick();
    check1("t5 in access", mem_req, 1'b1);
    rst = 1;
    tick();
    rst = 0; dm_req = 0;
    check1("t5 mem_req", mem_req, 1'b0);
    check32("t5 mem_addr", mem_addr, 32'h0);
    check1("t5 bus_err", bus_err, 1'b0);
    check1("t5 dm_done", dm_done, 1'b0);
    tick();
    mem_ack = 1; mem_rdata = 32'h77;
    tick();
    mem_ack = 0;
    check1("t5 stale done", dm_done | if_done, 1'b0);
    check1("t5 stale err", err, 1'b0);
    check1("t5 stale mem_req", mem_req, 1'b0);
    if_req = 1; if_addr = 32'h50;
    tick();
    check1("t5 new mem_req", mem_req, 1'b1);
    check32("t5 new addr", mem_addr, 32'h50);
    mem_ack = 1; mem_rdata = 32'h0000_ABCD;
    tick();
    mem_ack = 0; if_req = 0;
    check1("t5 if_done", if_done, 1'b1);
    check32("t5 if_rdata", if_rdata, 32'h0000_ABCD);
    tick();

    // Data request withdrawn mid-access still completes.
    dm_req = 1; dm_we = 0; dm_addr = 32'h500;
    tick();
    dm_req = 0;
    check1("t6 mem_req", mem_req, 1'b1);
    tick();
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'h22;
    tick();
    mem_ack = 0;
    check1("t6 dm_done", dm_done, 1'b1);
    check32("t6 dm_rdata", dm_rdata, 32'h22);
    tick();
    check1("t6 idle", mem_req | dm_done, 1'b0);

    // Randomized traffic against the transaction-level model.
    act = 0; ifp = 0; dmp = 0; starve = 0; t_start = 0; ack_at = 0; own_dm = 0;
    for (int n = 0; n < 900; n++) begin
      idle    = !act;
      in_acc  = act && (n > t_start) && (n <= ack_at);
      in_resp = act && (n == ack_at + 1);
      check1("rnd mem_req", mem_req, in_acc);
      check1("rnd if_done", if_done, in_resp && !own_dm);
      check1("rnd dm_done", dm_done, in_resp && own_dm);
      check1("rnd err", err, 1'b0);
      check1("rnd bus_err", bus_err, 1'b0);
      if (in_acc) begin
        check32("rnd mem_addr", mem_addr, cmd_addr);
        check1("rnd mem_we", mem_we, cmd_we);
        check32("rnd mem_be", {28'h0, mem_be}, {28'h0, cmd_be});
        if (cmd_we) check32("rnd mem_wdata", mem_wdata, cmd_wdata);
      end
      if (in_resp) begin
        if (own_dm) begin
          check32("rnd dm_rdata", dm_rdata, exp_rd);
          dmp = 0;
        end else begin
          check32("rnd if_rdata", if_rdata, exp_rd);
          ifp = 0;
        end
        act = 0;
      end
      if (!ifp && $urandom_range(0, 2) == 0) begin
        ifp = 1;
        ifa = $urandom_range(0, 32'hFFF);
      end
      if (!dmp && $urandom_range(0, 2) == 0) begin
        dmp  = 1;
        dmwe = 1'($urandom_range(0, 1));
        dma  = 32'h0001_0000 + $urandom_range(0, 63);
        dmw  = $urandom;
        dmb  = 4'($urandom);
      end
      if (idle) begin
        if (!ifp) starve = 0;
        if (ifp || dmp) begin
          own_dm = dmp && !(ifp && starve == SM);
          if (own_dm) begin
            if (ifp) starve = (starve < SM) ? starve + 1 : SM;
            cmd_addr = dma; cmd_we = dmwe; cmd_be = dmb; cmd_wdata = dmw;
          end else begin
            starve = 0;
            cmd_addr = ifa & ~32'h3; cmd_we = 0; cmd_be = 4'hF; cmd_wdata = 0;
          end
          act     = 1;
          t_start = n;
          ack_at  = n + 1 + int'($urandom_range(0, 3));
        end
      end
      mem_ack   = 0;
      mem_rdata = $urandom;
      if (act && n == ack_at) begin
        mem_ack = 1;
        if (cmd_we) begin
          mem_write(cmd_addr, cmd_wdata, cmd_be);
          exp_rd = 0;
        end else begin
          exp_rd    = mem_read(cmd_addr);
          mem_rdata = exp_rd;
        end
      end else if (!(act && n > t_start && n <= ack_at) && $urandom_range(0, 3) == 0) begin
        mem_ack = 1;
      end
      if_req   = ifp;
      if_addr  = ifp ? ifa : $urandom;
      dm_req   = dmp;
      dm_we    = dmp ? dmwe : 1'($urandom);
      dm_addr  = dmp ? dma : $urandom;
      dm_wdata = dmp ? dmw : $urandom;
      dm_be    = dmp ? dmb : 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
